led_breathe_pwm: RTL

LED breathing driver that consumes the terminal-count tick of the free-running PLL-clocked counter. Each tick advances a duty-cycle ramp (rise, hold high, fall, hold low). An internal PWM phase counter converts the ramp value into a glitch-free pulse train on an LED pin. It replaces the direct "counter MSB to D5" connection in the icestick top level.

---
 rtl/led_breathe_pwm_if.sv | 30 +++
 rtl/led_breathe_pwm.sv | 104 ++++++++++
 2 files changed

// File: rtl/led_breathe_pwm_if.sv
// Control and status bundle for the LED breathing driver.
// The slave side is the driver itself; the master side supplies EN/TICK and observes the outputs.
interface led_breathe_pwm_if #(
  parameter int WIDTH = 8
);
  logic             EN;
  logic             TICK;
  logic             LED;
  logic [WIDTH-1:0] DUTY;
  logic [1:0]       STATE;
  logic             OVERRUN;

  modport master (
    output EN,
    output TICK,
    input  LED,
    input  DUTY,
    input  STATE,
    input  OVERRUN
  );

  modport slave (
    input  EN,
    input  TICK,
    output LED,
    output DUTY,
    output STATE,
    output OVERRUN
  );
endinterface

// File: rtl/led_breathe_pwm.sv
// LED breathing driver: ticks step a rise/hold/fall/hold duty ramp that drives a free-running PWM.
// Latency: DUTY/STATE update on the edge ending the phase-wrap cycle; LED lags the compare by 1 cycle.
// Backpressure: none; surplus ticks within one PWM period coalesce and are flagged on OVERRUN.
module led_breathe_pwm #(
  parameter int WIDTH      = 8,
  parameter int STEP       = 1,
  parameter int HOLD_TICKS = 4
) (
  input  logic             CLK,
  input  logic             RESET,
  led_breathe_pwm_if.slave bus
);
  localparam int               HCW      = $clog2(HOLD_TICKS + 1);
  localparam logic [WIDTH-1:0] DUTY_MAX = '1;
  localparam logic [WIDTH-1:0] STEP_N   = WIDTH'(STEP);

  typedef enum logic [1:0] {
    RISE    = 2'd0,
    HOLD_HI = 2'd1,
    FALL    = 2'd2,
    HOLD_LO = 2'd3
  } ramp_state_t;

  ramp_state_t      state_q, state_d;
  logic [WIDTH-1:0] phase_q;
  logic [WIDTH-1:0] duty_q, duty_d;
  logic [HCW-1:0]   hold_cnt_q, hold_cnt_d;
  logic             pending_q;
  logic             led_q;
  logic             overrun_q;
  logic             tick_acc;
  logic             boundary;
  logic             update;
  logic [WIDTH:0]   duty_sum;
  logic [WIDTH-1:0] duty_dec;

  assign tick_acc = bus.TICK & bus.EN;
  assign boundary = (phase_q == DUTY_MAX);
  // A tick landing on the boundary is consumed there directly, never parked in pending.
  assign update   = boundary & bus.EN & (pending_q | tick_acc);
  assign duty_sum = {1'b0, duty_q} + {1'b0, STEP_N};
  assign duty_dec = (duty_q >= STEP_N) ? (duty_q - STEP_N) : '0;

  always_comb begin
    state_d    = state_q;
    duty_d     = duty_q;
    hold_cnt_d = hold_cnt_q;
    if (update) begin
      unique case (state_q)
        RISE: begin
          duty_d = duty_sum[WIDTH] ? DUTY_MAX : duty_sum[WIDTH-1:0];
          if (duty_d == DUTY_MAX) begin
            state_d    = HOLD_HI;
            hold_cnt_d = HCW'(HOLD_TICKS);
          end
        end
        FALL: begin
          duty_d = duty_dec;
          if (duty_dec == '0) begin
            state_d    = HOLD_LO;
            hold_cnt_d = HCW'(HOLD_TICKS);
          end
        end
        HOLD_HI, HOLD_LO: begin
          if (hold_cnt_q == HCW'(1)) begin
            state_d = (state_q == HOLD_HI) ? FALL : RISE;
          end else begin
            hold_cnt_d = hold_cnt_q - HCW'(1);
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      phase_q    <= '0;
      duty_q     <= '0;
      state_q    <= RISE;
      hold_cnt_q <= '0;
      pending_q  <= 1'b0;
      led_q      <= 1'b0;
      overrun_q  <= 1'b0;
    end else begin
      phase_q    <= phase_q + 1'b1;
      duty_q     <= duty_d;
      state_q    <= state_d;
      hold_cnt_q <= hold_cnt_d;
      led_q      <= (phase_q < duty_q);
      overrun_q  <= tick_acc & pending_q & ~boundary;
      if (update) begin
        pending_q <= 1'b0;
      end else if (tick_acc) begin
        pending_q <= 1'b1;
      end
    end
  end

  assign bus.LED     = led_q;
  assign bus.DUTY    = duty_q;
  assign bus.STATE   = state_q;
  assign bus.OVERRUN = overrun_q;
endmodule
